simon_cfg_axil_master: RTL
==========================

SIMON_CFG_AXIL_MASTER -- requirements
Module: simon_cfg_axil_master

Interface
REQ-001 SHALL have parameter CFG_ADDR_WIDTH, default 32: AXI-Lite address width.
REQ-002 SHALL have parameter CFG_DATA_WIDTH, default 32: AXI-Lite data width.
REQ-003 SHALL have parameter CFG_PROT_WIDTH, default 1: AxPROT width; the block drives it all-zero.
REQ-004 SHALL have one clock and one reset: the reset is synchronous and active-high.
- clk_simon_cfg  in  1  sole clock; all logic on its rising edge.
- rst_simon_cfg  in  1  synchronous active-high reset.
REQ-005 SHALL have these command/response ports:
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  CFG_ADDR_WIDTH  register byte address.
- cmd_wdata  in  CFG_DATA_WIDTH  write data.
- cmd_wstrb  in  CFG_DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  CFG_DATA_WIDTH  read data; zero for writes.
- rsp_resp  out  2  BRESP or RRESP.
- rsp_write  out  1  echo of cmd_write.
- stat_wr_count, stat_rd_count, stat_err_count  out  16 each  completed-transaction counters.
REQ-006 SHALL have AXI-Lite initiator ports: simon_cfg_awaddr/awprot/awvalid (out), awready (in); simon_cfg_wdata/wstrb/wvalid (out), wready (in); simon_cfg_bresp[1:0]/bvalid (in), bready (out); simon_cfg_araddr/arprot/arvalid (out), arready (in); simon_cfg_rdata/rresp[1:0]/rvalid (in), rready (out).

Function
REQ-007 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-008 SHALL assert cmd_ready only in IDLE, combinationally from state; cmd_valid&cmd_ready moves to WR_REQ (cmd_write=1) or RD_REQ, capturing addr/wdata/wstrb.
REQ-009 SHALL assert awvalid and wvalid from the registered state on the cycle after acceptance; each SHALL fall independently after its own handshake and never before it; inputs stay stable while valid.
REQ-010 SHALL leave WR_REQ for WR_RESP once both AW and W handshakes are done, in either order or the same cycle.
REQ-011 SHALL assert bready only in WR_RESP; bvalid&bready captures bresp and moves to RSP.
REQ-012 SHALL assert arvalid in RD_REQ until arready; then RD_RESP with rready=1; rvalid&rready captures rdata/rresp and moves to RSP.
REQ-013 SHALL hold rsp_valid=1 with stable rsp_* in RSP until rsp_ready; the handshake returns to IDLE, so the next command is accepted one cycle later at the earliest.
REQ-014 SHALL give a minimum latency, with a zero-wait responder, of 3 cycles from command acceptance to rsp_valid.
REQ-015 SHALL tolerate bvalid/rvalid arriving outside WR_RESP/RD_RESP by not asserting ready, so the responder holds.
REQ-016 SHALL increment stat_wr_count or stat_rd_count on each rsp handshake, and stat_err_count when rsp_resp[1]=1; all counters saturate at 16'hFFFF.
REQ-017 SHALL allow at most one outstanding transaction.

Reset
REQ-018 SHALL, while rst_simon_cfg=1, go to IDLE on the next edge, mid-transaction included, and drive: all valid and ready outputs 0; rsp_* 0; counters 0; captured registers 0.
REQ-019 SHALL assert cmd_ready on the first cycle after reset deasserts.

Structure
REQ-020 SHALL place the FSM state enum and the AXI response constants OKAY=2'b00 and SLVERR=2'b10 in shared package simon_pkg.
REQ-021 SHALL use sub-module simon_sat_counter (16-bit saturating), instantiated three times.

Verification
REQ-022 SHALL cover a write with a zero-wait responder: addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> awaddr=0x10 and wdata match; rsp_valid 3 cycles after acceptance; rsp_resp=00; stat_wr_count=1.
REQ-023 SHALL cover a read: addr 0x20; responder returns rdata 0x12345678 after 4 wait cycles on arready -> rsp_rdata=0x12345678, rsp_write=0, stat_rd_count=1.
REQ-024 SHALL cover skew: awready 5 cycles before wready, and the reverse case -> each valid drops only after its own handshake; exactly one B is consumed.
REQ-025 SHALL cover an error: bresp=2'b10 -> rsp_resp=10, stat_err_count=1; rsp_ready held low 10 cycles -> rsp_* stable and cmd_ready=0 throughout.
REQ-026 SHALL cover reset mid-read, asserted in RD_RESP -> next cycle arvalid=rready=rsp_valid=0, counters 0; cmd_ready=1 after release.
REQ-027 SHALL cover saturation: counters preloaded near 16'hFFFF, then 3 writes -> stat_wr_count stays 16'hFFFF.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON configuration AXI-Lite master.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } simon_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic inc);
    return (inc && (v != STAT_MAX)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/simon_cfg_axil_master_if.sv
// AXI-Lite bus between the configuration master and its register responder.
interface simon_cfg_axil_master_if #(
  parameter int CFG_ADDR_WIDTH = 32,
  parameter int CFG_DATA_WIDTH = 32,
  parameter int CFG_PROT_WIDTH = 1
);
  logic [CFG_ADDR_WIDTH-1:0]   simon_cfg_awaddr;
  logic [CFG_PROT_WIDTH-1:0]   simon_cfg_awprot;
  logic                        simon_cfg_awvalid;
  logic                        simon_cfg_awready;
  logic [CFG_DATA_WIDTH-1:0]   simon_cfg_wdata;
  logic [CFG_DATA_WIDTH/8-1:0] simon_cfg_wstrb;
  logic                        simon_cfg_wvalid;
  logic                        simon_cfg_wready;
  logic [1:0]                  simon_cfg_bresp;
  logic                        simon_cfg_bvalid;
  logic                        simon_cfg_bready;
  logic [CFG_ADDR_WIDTH-1:0]   simon_cfg_araddr;
  logic [CFG_PROT_WIDTH-1:0]   simon_cfg_arprot;
  logic                        simon_cfg_arvalid;
  logic                        simon_cfg_arready;
  logic [CFG_DATA_WIDTH-1:0]   simon_cfg_rdata;
  logic [1:0]                  simon_cfg_rresp;
  logic                        simon_cfg_rvalid;
  logic                        simon_cfg_rready;

  modport master (
    output simon_cfg_awaddr, simon_cfg_awprot, simon_cfg_awvalid,
    input  simon_cfg_awready,
    output simon_cfg_wdata, simon_cfg_wstrb, simon_cfg_wvalid,
    input  simon_cfg_wready,
    input  simon_cfg_bresp, simon_cfg_bvalid,
    output simon_cfg_bready,
    output simon_cfg_araddr, simon_cfg_arprot, simon_cfg_arvalid,
    input  simon_cfg_arready,
    input  simon_cfg_rdata, simon_cfg_rresp, simon_cfg_rvalid,
    output simon_cfg_rready
  );

  modport slave (
    input  simon_cfg_awaddr, simon_cfg_awprot, simon_cfg_awvalid,
    output simon_cfg_awready,
    input  simon_cfg_wdata, simon_cfg_wstrb, simon_cfg_wvalid,
    output simon_cfg_wready,
    output simon_cfg_bresp, simon_cfg_bvalid,
    input  simon_cfg_bready,
    input  simon_cfg_araddr, simon_cfg_arprot, simon_cfg_arvalid,
    output simon_cfg_arready,
    output simon_cfg_rdata, simon_cfg_rresp, simon_cfg_rvalid,
    input  simon_cfg_rready
  );
endinterface

// File: rtl/simon_sat_counter.sv
// 16-bit event counter that saturates at all-ones; cleared by synchronous reset.
module simon_sat_counter
  import simon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = sat_inc(cnt_q, inc);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/simon_cfg_axil_master.sv
// Single-outstanding AXI-Lite initiator turning cmd/rsp requests into AW/W/B or AR/R bursts.
module simon_cfg_axil_master
  import simon_pkg::*;
#(
  parameter int CFG_ADDR_WIDTH = 32,
  parameter int CFG_DATA_WIDTH = 32,
  parameter int CFG_PROT_WIDTH = 1
) (
  input  logic                        clk_simon_cfg,
  input  logic                        rst_simon_cfg,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [CFG_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CFG_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [CFG_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [CFG_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_write,
  output logic [STAT_W-1:0]           stat_wr_count,
  output logic [STAT_W-1:0]           stat_rd_count,
  output logic [STAT_W-1:0]           stat_err_count,
  simon_cfg_axil_master_if.master     axi
);

  simon_state_e                state_q, state_d;
  logic [CFG_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CFG_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CFG_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [CFG_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        write_q, write_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;

  logic aw_hs, w_hs, rsp_hs;

  assign aw_hs  = axi.simon_cfg_awvalid && axi.simon_cfg_awready;
  assign w_hs   = axi.simon_cfg_wvalid && axi.simon_cfg_wready;
  assign rsp_hs = rsp_valid && rsp_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    write_d   = write_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          rdata_d   = '0;
          resp_d    = RESP_OKAY;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        // AW and W complete independently; move on once both have been seen.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (axi.simon_cfg_bvalid) begin
          resp_d  = axi.simon_cfg_bresp;
          state_d = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (axi.simon_cfg_arready) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (axi.simon_cfg_rvalid) begin
          rdata_d = axi.simon_cfg_rdata;
          resp_d  = axi.simon_cfg_rresp;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_simon_cfg) begin
    if (rst_simon_cfg) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // cmd_ready is masked during reset so nothing is accepted while the block is held.
  assign cmd_ready = (state_q == ST_IDLE) && !rst_simon_cfg;

  assign axi.simon_cfg_awaddr  = addr_q;
  assign axi.simon_cfg_awprot  = {CFG_PROT_WIDTH{1'b0}};
  assign axi.simon_cfg_awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
  assign axi.simon_cfg_wdata   = wdata_q;
  assign axi.simon_cfg_wstrb   = wstrb_q;
  assign axi.simon_cfg_wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
  assign axi.simon_cfg_bready  = (state_q == ST_WR_RESP);
  assign axi.simon_cfg_araddr  = addr_q;
  assign axi.simon_cfg_arprot  = {CFG_PROT_WIDTH{1'b0}};
  assign axi.simon_cfg_arvalid = (state_q == ST_RD_REQ);
  assign axi.simon_cfg_rready  = (state_q == ST_RD_RESP);

  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign rsp_write = write_q;

  logic wr_inc, rd_inc, err_inc;

  // Any response with the error bit set (SLVERR or DECERR) counts as an error.
  assign wr_inc  = rsp_hs && write_q;
  assign rd_inc  = rsp_hs && !write_q;
  assign err_inc = rsp_hs && ((resp_q & RESP_SLVERR) != 2'b00);

  simon_sat_counter u_wr_cnt (
    .clk   (clk_simon_cfg),
    .rst   (rst_simon_cfg),
    .inc   (wr_inc),
    .count (stat_wr_count)
  );

  simon_sat_counter u_rd_cnt (
    .clk   (clk_simon_cfg),
    .rst   (rst_simon_cfg),
    .inc   (rd_inc),
    .count (stat_rd_count)
  );

  simon_sat_counter u_err_cnt (
    .clk   (clk_simon_cfg),
    .rst   (rst_simon_cfg),
    .inc   (err_inc),
    .count (stat_err_count)
  );

endmodule
